// File: rtl/bot_motion_pkg.sv
// Shared encodings for the motion tracker: motion codes, compass headings,
// and the per-heading unit step used for location updates.
package bot_motion_pkg;

  typedef enum logic [2:0] {
    MOT_STOP   = 3'd0,
    MOT_FWD    = 3'd1,
    MOT_REV    = 3'd2,
    MOT_TURN_L = 3'd3,
    MOT_TURN_R = 3'd4,
    MOT_SPIN_L = 3'd5,
    MOT_SPIN_R = 3'd6
  } motion_e;

  typedef enum logic [2:0] {
    HEAD_N, HEAD_NE, HEAD_E, HEAD_SE, HEAD_S, HEAD_SW, HEAD_W, HEAD_NW
  } heading_e;

  // Two's-complement 8-bit steps so a plain add wraps mod 256.
  typedef struct packed {
    logic [7:0] dx;
    logic [7:0] dy;
  } step_t;

  localparam int IDLE_W = 12;

  function automatic step_t head_step(input logic [2:0] h);
    step_t s;
    s.dx = 8'h00;
    s.dy = 8'h00;
    case (heading_e'(h))
      HEAD_N:  s.dy = 8'h01;
      HEAD_NE: begin s.dx = 8'h01; s.dy = 8'h01; end
      HEAD_E:  s.dx = 8'h01;
      HEAD_SE: begin s.dx = 8'h01; s.dy = 8'hFF; end
      HEAD_S:  s.dy = 8'hFF;
      HEAD_SW: begin s.dx = 8'hFF; s.dy = 8'hFF; end
      HEAD_W:  s.dx = 8'hFF;
      HEAD_NW: begin s.dx = 8'hFF; s.dy = 8'h01; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bot_motion_tracker_if.sv
// Wheel-position inputs and tracker outputs; master is the robot core side,
// slave is the tracker.
interface bot_motion_tracker_if;
  logic [7:0]  left_pos;
  logic [7:0]  right_pos;
  logic [2:0]  motion;
  logic [2:0]  heading;
  logic [7:0]  loc_x;
  logic [7:0]  loc_y;
  logic        upd;
  logic        delta_err;
  logic [15:0] odometer;

  modport master (
    output left_pos, right_pos,
    input  motion, heading, loc_x, loc_y, upd, delta_err, odometer
  );

  modport slave (
    input  left_pos, right_pos,
    output motion, heading, loc_x, loc_y, upd, delta_err, odometer
  );
endinterface

// File: rtl/bot_wheel_delta.sv
// Per-wheel delta decoder: compares the position counter against last cycle's
// value and flags a +1 step, a -1 step, or an illegal jump.
module bot_wheel_delta (
  input  logic       clk,
  input  logic [7:0] pos,
  output logic       inc,
  output logic       dec,
  output logic       err
);
  logic [7:0] prev_q, prev_d, delta;

  always_comb begin
    prev_d = pos;
    delta  = pos - prev_q;
    inc    = (delta == 8'h01);
    dec    = (delta == 8'hFF);
    err    = !(inc || dec || (delta == 8'h00));
  end

  // NOTE: prev follows pos every cycle, reset included, so it needs no reset
  // branch and the first post-reset cycle never sees a spurious delta.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end
endmodule

// File: rtl/bot_motion_tracker.sv
// Wheel-odometry tracker: classifies motion, keeps heading and X/Y location.
// Optional feature macro: BOT_ODOMETER_EN (saturating FWD/REV event counter).
module bot_motion_tracker
  import bot_motion_pkg::*;
#(
  parameter int         TURN_STEPS = 2,
  parameter logic [7:0] INIT_X     = 8'd128,
  parameter logic [7:0] INIT_Y     = 8'd128,
  parameter logic [2:0] INIT_HEAD  = 3'd0
) (
  input logic                  clk,
  input logic                  reset,
  bot_motion_tracker_if.slave  bus
);
  localparam int ACC_W = $clog2(TURN_STEPS + 1) + 2;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(TURN_STEPS);

  logic l_inc, l_dec, l_err, r_inc, r_dec, r_err;
  logic l_any, r_any, ev;
  motion_e ev_mot;
  step_t   st;

  motion_e motion_q, motion_d;
  logic [2:0] head_q, head_d;
  logic [7:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;
  logic upd_q, upd_d, err_q, err_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [IDLE_W-1:0] since_q, since_d, since_inc, gap_q, gap_d;
  logic seen_q, seen_d, gap_ok_q, gap_ok_d;
  logic [IDLE_W+2:0] idle, stop_thr;

  bot_wheel_delta u_left  (.clk(clk), .pos(bus.left_pos),  .inc(l_inc), .dec(l_dec), .err(l_err));
  bot_wheel_delta u_right (.clk(clk), .pos(bus.right_pos), .inc(r_inc), .dec(r_dec), .err(r_err));

  always_comb begin
    // NOTE: every _d and temporary gets a value before any branch, so no
    // path through this block can infer a latch.
    motion_d = motion_q;
    head_d   = head_q;
    loc_x_d  = loc_x_q;
    loc_y_d  = loc_y_q;
    acc_d    = acc_q;
    since_d  = since_q;
    gap_d    = gap_q;
    seen_d   = seen_q;
    gap_ok_d = gap_ok_q;
    upd_d    = 1'b0;
    err_d    = err_q | l_err | r_err;
    acc_step = '0;
    st       = head_step(head_q);
    l_any    = l_inc | l_dec;
    r_any    = r_inc | r_dec;
    ev       = l_any | r_any;
    since_inc = (&since_q) ? since_q : since_q + IDLE_W'(1);
    // Idle time is since_q+1 cycles; STOP threshold is eight event gaps.
    idle     = {3'b000, since_q} + (IDLE_W + 3)'(1);
    stop_thr = {gap_q, 3'b000};

    ev_mot = MOT_STOP;
    if (l_inc && r_inc)                              ev_mot = MOT_FWD;
    else if (l_dec && r_dec)                         ev_mot = MOT_REV;
    else if (l_inc && r_dec)                         ev_mot = MOT_SPIN_R;
    else if (l_dec && r_inc)                         ev_mot = MOT_SPIN_L;
    else if ((l_inc && !r_any) || (!l_any && r_dec)) ev_mot = MOT_TURN_R;
    else if (ev)                                     ev_mot = MOT_TURN_L;

    if (ev) begin
      upd_d    = 1'b1;
      motion_d = ev_mot;
      since_d  = '0;
      seen_d   = 1'b1;
      if (seen_q) begin
        gap_d    = since_inc;
        gap_ok_d = 1'b1;
      end
      case (ev_mot)
        MOT_FWD: begin
          loc_x_d = loc_x_q + st.dx;
          loc_y_d = loc_y_q + st.dy;
          acc_d   = '0;
        end
        MOT_REV: begin
          loc_x_d = loc_x_q - st.dx;
          loc_y_d = loc_y_q - st.dy;
          acc_d   = '0;
        end
        MOT_SPIN_R: begin head_d = head_q + 3'd1; acc_d = '0; end
        MOT_SPIN_L: begin head_d = head_q - 3'd1; acc_d = '0; end
        MOT_TURN_R: begin
          // A turn against the accumulated direction restarts the count.
          acc_step = (acc_q < 0) ? ACC_ONE : acc_q + ACC_ONE;
          if (acc_step == ACC_MAX) begin
            head_d = head_q + 3'd1;
            acc_d  = '0;
          end else begin
            acc_d  = acc_step;
          end
        end
        MOT_TURN_L: begin
          acc_step = (acc_q > 0) ? -ACC_ONE : acc_q - ACC_ONE;
          if (acc_step == -ACC_MAX) begin
            head_d = head_q - 3'd1;
            acc_d  = '0;
          end else begin
            acc_d  = acc_step;
          end
        end
        default: ;
      endcase
    end else begin
      since_d = since_inc;
      if (gap_ok_q && (idle >= stop_thr)) motion_d = MOT_STOP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      motion_q <= MOT_STOP;
      head_q   <= INIT_HEAD;
      loc_x_q  <= INIT_X;
      loc_y_q  <= INIT_Y;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      since_q  <= '0;
      gap_q    <= '0;
      seen_q   <= 1'b0;
      gap_ok_q <= 1'b0;
    end else begin
      motion_q <= motion_d;
      head_q   <= head_d;
      loc_x_q  <= loc_x_d;
      loc_y_q  <= loc_y_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      since_q  <= since_d;
      gap_q    <= gap_d;
      seen_q   <= seen_d;
      gap_ok_q <= gap_ok_d;
    end
  end

`ifdef BOT_ODOMETER_EN
  logic [15:0] odo_q, odo_d;

  always_comb begin
    odo_d = odo_q;
    if (ev && (ev_mot == MOT_FWD || ev_mot == MOT_REV) && (odo_q != 16'hFFFF))
      odo_d = odo_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) odo_q <= 16'h0000;
    else       odo_q <= odo_d;
  end

  assign bus.odometer = odo_q;
`else
  assign bus.odometer = 16'h0000;
`endif

  assign bus.motion    = motion_q;
  assign bus.heading   = head_q;
  assign bus.loc_x     = loc_x_q;
  assign bus.loc_y     = loc_y_q;
  assign bus.upd       = upd_q;
  assign bus.delta_err = err_q;
endmodule

// File: tb/tb_bot_motion_tracker.sv
// Self-checking bench for bot_motion_tracker: directed scenarios plus a
// randomized run against a cycle-indexed behavioural model.
module tb_bot_motion_tracker;
  localparam int TS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bot_motion_tracker_if bus();

  bot_motion_tracker #(
    .TURN_STEPS(TS), .INIT_X(8'd128), .INIT_Y(8'd128), .INIT_HEAD(3'd0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: motion codes 0=STOP 1=FWD 2=REV 3=TURN_L 4=TURN_R 5=SPIN_L 6=SPIN_R
  int m_x, m_y, m_head, m_acc, m_mot, m_odo, cyc;
  bit m_err, m_upd;
  int ev_t[$];
  int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dys[8] = '{1, 1, 0, -1, -1, -1, 0, 1};

  task automatic model_reset();
    m_x = 128; m_y = 128; m_head = 0; m_acc = 0; m_mot = 0; m_odo = 0;
    m_err = 1'b0; m_upd = 1'b0; cyc = 0;
    ev_t.delete();
  endtask

  task automatic model_cycle(input int dl, input int dr);
    int l, r, last, gap;
    l = (dl == 1) ? 1 : (dl == 255) ? -1 : 0;
    r = (dr == 1) ? 1 : (dr == 255) ? -1 : 0;
    if (!(dl == 0 || dl == 1 || dl == 255)) m_err = 1'b1;
    if (!(dr == 0 || dr == 1 || dr == 255)) m_err = 1'b1;
    cyc++;
    if (l != 0 || r != 0) begin
      m_upd = 1'b1;
      ev_t.push_back(cyc);
      if (ev_t.size() > 2) void'(ev_t.pop_front());
      if (l == 1 && r == 1)        m_mot = 1;
      else if (l == -1 && r == -1) m_mot = 2;
      else if (l == 1 && r == -1)  m_mot = 6;
      else if (l == -1 && r == 1)  m_mot = 5;
      else if ((l == 1 && r == 0) || (l == 0 && r == -1)) m_mot = 4;
      else                         m_mot = 3;
      case (m_mot)
        1: begin m_x = (m_x + dxs[m_head] + 256) % 256; m_y = (m_y + dys[m_head] + 256) % 256; m_acc = 0; end
        2: begin m_x = (m_x - dxs[m_head] + 256) % 256; m_y = (m_y - dys[m_head] + 256) % 256; m_acc = 0; end
        6: begin m_head = (m_head + 1) % 8; m_acc = 0; end
        5: begin m_head = (m_head + 7) % 8; m_acc = 0; end
        4: begin
          m_acc = (m_acc < 0) ? 1 : m_acc + 1;
          if (m_acc == TS) begin m_head = (m_head + 1) % 8; m_acc = 0; end
        end
        default: begin
          m_acc = (m_acc > 0) ? -1 : m_acc - 1;
          if (m_acc == -TS) begin m_head = (m_head + 7) % 8; m_acc = 0; end
        end
      endcase
      if ((m_mot == 1 || m_mot == 2) && m_odo < 65535) m_odo++;
    end else begin
      m_upd = 1'b0;
      if (ev_t.size() == 2) begin
        last = ev_t[1];
        gap  = ev_t[1] - ev_t[0];
        if (cyc - last >= 8 * gap) m_mot = 0;
      end
    end
  endtask

  // One cycle: change inputs after negedge, sample #1 after the next posedge.
  task automatic step(input int dl, input int dr);
    @(negedge clk);
    bus.left_pos  = bus.left_pos + 8'(dl);
    bus.right_pos = bus.right_pos + 8'(dr);
    model_cycle(dl, dr);
    @(posedge clk);
    #1;
  endtask

  // Inputs also move during reset; that change must be discarded.
  task automatic do_reset(input logic [7:0] lp, input logic [7:0] rp);
    @(negedge clk);
    reset = 1'b1;
    bus.left_pos = lp;
    bus.right_pos = rp;
    @(negedge clk);
    bus.left_pos = lp + 8'd1;
    bus.right_pos = rp + 8'd1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic int exp_odo(input int v);
`ifdef BOT_ODOMETER_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic test_reset();
    bus.left_pos = 8'h00; bus.right_pos = 8'h00;
    step(1, 1);
    do_reset(8'h40, 8'h40);
    n_tests++; if (bus.motion !== 3'd0) begin n_fail++; $display("FAIL reset_motion: got %0d expected 0", bus.motion); end
    n_tests++; if (bus.heading !== 3'd0) begin n_fail++; $display("FAIL reset_heading: got %0d expected 0", bus.heading); end
    n_tests++; if (bus.loc_x !== 8'd128 || bus.loc_y !== 8'd128) begin n_fail++; $display("FAIL reset_loc: got (%0d,%0d) expected (128,128)", bus.loc_x, bus.loc_y); end
    n_tests++; if (bus.upd !== 1'b0 || bus.delta_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got upd=%0b err=%0b expected 0 0", bus.upd, bus.delta_err); end
    n_tests++; if (bus.odometer !== 16'd0) begin n_fail++; $display("FAIL reset_odo: got %0d expected 0", bus.odometer); end
    step(0, 0);
    n_tests++; if (bus.upd !== 1'b0 || bus.motion !== 3'd0) begin n_fail++; $display("FAIL reset_no_event: got upd=%0b motion=%0d expected 0 0", bus.upd, bus.motion); end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      n_tests++; if (bus.upd !== 1'b1 || bus.motion !== 3'd1) begin n_fail++; $display("FAIL fwd_upd_motion[%0d]: got upd=%0b motion=%0d expected 1 1", i, bus.upd, bus.motion); end
      n_tests++; if (bus.loc_y !== 8'(129 + i) || bus.loc_x !== 8'd128) begin n_fail++; $display("FAIL fwd_loc[%0d]: got (%0d,%0d) expected (128,%0d)", i, bus.loc_x, bus.loc_y, 129 + i); end
    end
    step(0, 0);
    n_tests++; if (bus.upd !== 1'b0 || bus.motion !== 3'd1 || bus.loc_y !== 8'd131) begin n_fail++; $display("FAIL fwd_hold: got upd=%0b motion=%0d y=%0d expected 0 1 131", bus.upd, bus.motion, bus.loc_y); end
  endtask

  task automatic test_spin();
    do_reset(8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step(1, 255);
      n_tests++; if (bus.heading !== 3'(i + 1) || bus.motion !== 3'd6) begin n_fail++; $display("FAIL spin_r[%0d]: got head=%0d motion=%0d expected %0d 6", i, bus.heading, bus.motion, i + 1); end
    end
    step(1, 1);
    n_tests++; if (bus.loc_x !== 8'd129 || bus.loc_y !== 8'd128) begin n_fail++; $display("FAIL spin_fwd_east: got (%0d,%0d) expected (129,128)", bus.loc_x, bus.loc_y); end
    for (int i = 0; i < 3; i++) begin
      step(255, 1);
      n_tests++; if (bus.heading !== 3'((9 - i) % 8) || bus.motion !== 3'd5) begin n_fail++; $display("FAIL spin_l[%0d]: got head=%0d motion=%0d expected %0d 5", i, bus.heading, bus.motion, (9 - i) % 8); end
    end
  endtask

  task automatic test_turn();
    int exp_h[3] = '{0, 1, 1};
    do_reset(8'h80, 8'h80);
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      n_tests++; if (bus.heading !== 3'(exp_h[i]) || bus.motion !== 3'd4) begin n_fail++; $display("FAIL turn_r[%0d]: got head=%0d motion=%0d expected %0d 4", i, bus.heading, bus.motion, exp_h[i]); end
    end
    step(0, 1);
    n_tests++; if (bus.heading !== 3'd1 || bus.motion !== 3'd3) begin n_fail++; $display("FAIL turn_reverse: got head=%0d motion=%0d expected 1 3", bus.heading, bus.motion); end
    step(0, 1);
    n_tests++; if (bus.heading !== 3'd0) begin n_fail++; $display("FAIL turn_l_complete: got head=%0d expected 0", bus.heading); end
    step(0, 255);
    n_tests++; if (bus.heading !== 3'd0 || bus.motion !== 3'd4) begin n_fail++; $display("FAIL turn_r_right_back: got head=%0d motion=%0d expected 0 4", bus.heading, bus.motion); end
    step(255, 0);
    n_tests++; if (bus.heading !== 3'd0 || bus.motion !== 3'd3) begin n_fail++; $display("FAIL turn_l_left_back: got head=%0d motion=%0d expected 0 3", bus.heading, bus.motion); end
  endtask

  task automatic test_wrap();
    do_reset(8'h00, 8'h00);
    step(1, 255);
    for (int i = 0; i < 127; i++) step(1, 1);
    n_tests++; if (bus.loc_x !== 8'd255 || bus.loc_y !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got (%0d,%0d) expected (255,255)", bus.loc_x, bus.loc_y); end
    step(1, 1);
    n_tests++; if (bus.loc_x !== 8'd0 || bus.loc_y !== 8'd0) begin n_fail++; $display("FAIL wrap_ne: got (%0d,%0d) expected (0,0)", bus.loc_x, bus.loc_y); end
    step(255, 1);
    step(1, 1);
    step(255, 255);
    step(255, 255);
    n_tests++; if (bus.loc_y !== 8'd255 || bus.loc_x !== 8'd0 || bus.motion !== 3'd2) begin n_fail++; $display("FAIL wrap_rev: got (%0d,%0d) motion=%0d expected (0,255) 2", bus.loc_x, bus.loc_y, bus.motion); end
  endtask

  task automatic test_delta_err();
    do_reset(8'h10, 8'h20);
    step(3, 0);
    n_tests++; if (bus.delta_err !== 1'b1 || bus.upd !== 1'b0) begin n_fail++; $display("FAIL err_jump: got err=%0b upd=%0b expected 1 0", bus.delta_err, bus.upd); end
    step(3, 1);
    n_tests++; if (bus.upd !== 1'b1 || bus.motion !== 3'd3 || bus.heading !== 3'd0) begin n_fail++; $display("FAIL err_other_wheel: got upd=%0b motion=%0d head=%0d expected 1 3 0", bus.upd, bus.motion, bus.heading); end
    step(1, 1);
    n_tests++; if (bus.delta_err !== 1'b1 || bus.loc_y !== 8'd129) begin n_fail++; $display("FAIL err_sticky: got err=%0b y=%0d expected 1 129", bus.delta_err, bus.loc_y); end
    do_reset(8'h10, 8'h20);
    n_tests++; if (bus.delta_err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %0b expected 0", bus.delta_err); end
  endtask

  task automatic test_odometer();
    do_reset(8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 1);
    for (int i = 0; i < 2; i++) step(255, 255);
    step(1, 0);
    n_tests++; if (bus.odometer !== 16'(exp_odo(7))) begin n_fail++; $display("FAIL odometer: got %0d expected %0d", bus.odometer, exp_odo(7)); end
  endtask

  task automatic test_stop();
    do_reset(8'h00, 8'h00);
    step(1, 1);
    for (int i = 0; i < 20; i++) step(0, 0);
    n_tests++; if (bus.motion !== 3'd1) begin n_fail++; $display("FAIL stop_gap_unknown: got %0d expected 1", bus.motion); end
    do_reset(8'h00, 8'h00);
    step(1, 1);
    step(1, 1);
    for (int i = 0; i < 7; i++) step(0, 0);
    n_tests++; if (bus.motion !== 3'd1) begin n_fail++; $display("FAIL stop_early_g1: got %0d expected 1", bus.motion); end
    step(0, 0);
    n_tests++; if (bus.motion !== 3'd0 || bus.upd !== 1'b0) begin n_fail++; $display("FAIL stop_g1: got motion=%0d upd=%0b expected 0 0", bus.motion, bus.upd); end
    step(1, 1);
    step(0, 0);
    step(1, 1);
    for (int i = 0; i < 15; i++) step(0, 0);
    n_tests++; if (bus.motion !== 3'd1) begin n_fail++; $display("FAIL stop_early_g2: got %0d expected 1", bus.motion); end
    step(0, 0);
    n_tests++; if (bus.motion !== 3'd0) begin n_fail++; $display("FAIL stop_g2: got %0d expected 0", bus.motion); end
  endtask

  function automatic int rnd_delta();
    int k;
    k = int'($urandom_range(0, 15));
    if (k == 0) return int'($urandom_range(2, 254));
    else if (k < 6) return 0;
    else if (k < 11) return 1;
    else return 255;
  endfunction

  task automatic test_random();
    for (int blk = 0; blk < 3; blk++) begin
      do_reset(8'($urandom), 8'($urandom));
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          for (int j = 0; j < int'($urandom_range(0, 20)); j++) step(0, 0);
        end else begin
          step(rnd_delta(), rnd_delta());
        end
        n_tests++; if (bus.upd !== m_upd) begin n_fail++; $display("FAIL rnd_upd @%0d: got %0b expected %0b", cyc, bus.upd, m_upd); end
        n_tests++; if (bus.motion !== 3'(m_mot)) begin n_fail++; $display("FAIL rnd_motion @%0d: got %0d expected %0d", cyc, bus.motion, m_mot); end
        n_tests++; if (bus.heading !== 3'(m_head)) begin n_fail++; $display("FAIL rnd_heading @%0d: got %0d expected %0d", cyc, bus.heading, m_head); end
        n_tests++; if (bus.loc_x !== 8'(m_x) || bus.loc_y !== 8'(m_y)) begin n_fail++; $display("FAIL rnd_loc @%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, bus.loc_x, bus.loc_y, m_x, m_y); end
        n_tests++; if (bus.delta_err !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %0b expected %0b", cyc, bus.delta_err, m_err); end
        n_tests++; if (bus.odometer !== 16'(exp_odo(m_odo))) begin n_fail++; $display("FAIL rnd_odo @%0d: got %0d expected %0d", cyc, bus.odometer, exp_odo(m_odo)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_spin();
    test_turn();
    test_wrap();
    test_delta_err();
    test_odometer();
    test_stop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
